fifo_rd_ptr_ctrl: RTL and testbench
===================================

Name: fifo_rd_ptr_ctrl

Overview:
Read-side pointer and empty-flag controller for the dual-clock FIFO. Lives entirely in the read clock domain.
- Synchronizes the incoming Gray-coded write pointer.
- Advances the binary/Gray read pointer on accepted reads.
- Produces a registered empty flag by Gray-pointer equality.
- Outputs the read Gray pointer for the write-side full comparator and the RAM read address.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, flop stages in the write-pointer synchronizer (legal range 2..4).
AE_THRESH, 1, almost-empty threshold in entries (used only with the optional feature).

Ports:
clk  input  1  read-domain clock, rising edge.
rst  input  1  synchronous, active-high reset.
rd_en  input  1  read request from the consumer.
wr_ptr_gray  input  ADDR_W+1  write Gray pointer, launched from the write domain (asynchronous to clk).
rd_ptr_gray  output  ADDR_W+1  registered read Gray pointer, sent to the write domain.
rd_addr  output  ADDR_W  RAM read address, equal to rd_ptr_bin[ADDR_W-1:0].
rd_fire  output  1  read accepted this cycle (rd_en & ~empty).
empty  output  1  registered FIFO-empty flag.
underflow  output  1  one-cycle pulse when rd_en is asserted while empty.
almost_empty  output  1  level <= AE_THRESH (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - rd_ptr_bin=0, rd_ptr_gray=0, all synchronizer stages=0.
  - empty=1, almost_empty=1, underflow=0.
  - rd_en is ignored in that cycle.
  - Reset mid-operation discards all pointer state on the next edge.
- Synchronizer: wq_sync is the last stage of a SYNC_STAGES-deep flop chain sampling wr_ptr_gray. No logic between stages.
- Read acceptance: rd_fire = rd_en & ~empty, combinational from the registered empty.
- Pointer update:
  - rd_bin_next = rd_ptr_bin + rd_fire, modulo 2**(ADDR_W+1). The wrap of the MSB is the lap bit.
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - Both pointers register rd_*_next every cycle.
- Empty: empty <= (rd_gray_next == wq_sync). This is a full ADDR_W+1-bit equality, including the MSB.
- Latency:
  - A write-pointer change is visible at wq_sync after SYNC_STAGES edges; empty deasserts on edge SYNC_STAGES+1.
  - A read that drains the last entry asserts empty on the same edge that advances the pointer, so there is no extra read.
- Simultaneous read and incoming write pointer change: compare against the current wq_sync only. The write becomes visible later. This is conservative: empty never falsely deasserts.
- Underflow: underflow <= rd_en & empty. The pointer does not move. It is a one-cycle pulse per offending cycle, not sticky.
- rd_addr is derived from the registered rd_ptr_bin, so there are zero combinational paths from rd_en to rd_addr.

Optional Feature:
Macro FIFO_RD_ALMOST_EMPTY_EN.
- Defined:
  - wbin = gray2bin(wq_sync).
  - level = (wbin - rd_bin_next) mod 2**(ADDR_W+1).
  - almost_empty <= (level <= AE_THRESH), registered; reset value 1.
- Undefined: no gray2bin logic is built; almost_empty is driven equal to empty.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parameterized by width;
  - constants DEF_ADDR_W=4, DEF_SYNC_STAGES=2.
- One sub-module: sync_ff_n (N-bit, STAGES-deep flop synchronizer, clk/rst, reset to 0). It is reused by the write-side controller.

Test Plan:
All scenarios use ADDR_W=2, SYNC_STAGES=2, pointer width 3.
1. Hold rst=1 for 2 cycles with rd_en=1 -> empty=1, rd_ptr_gray=000, rd_addr=0, underflow=0, rd_fire=0.
2. Change wr_ptr_gray 000->001 at edge 0 -> empty stays 1 through edge 2 and reads 0 after edge 3. Then one rd_en pulse -> rd_fire=1, and after the edge rd_ptr_gray=001, rd_addr=1, empty=1.
3. Assert rd_en while empty=1 -> underflow=1 for exactly one cycle, rd_ptr_gray unchanged, rd_fire=0.
4. Wrap-around: step wr_ptr_gray through bin 0..7,0 (Gray 000,001,011,010,110,111,101,100,000) and read continuously -> rd_addr sequence 0,1,2,3,0,1,2,3 and rd_ptr_gray returns to 000. Empty must never deassert when pointers are equal including the MSB, e.g. rd=wr=100.
5. Reset mid-operation at rd_ptr_bin=5 (Gray 111) with rd_en=1 -> next edge rd_ptr_gray=000, rd_addr=0, empty=1, underflow=0.
6. With FIFO_RD_ALMOST_EMPTY_EN and AE_THRESH=1: wr bin=3 (Gray 010) synced, rd=0 -> level 3, almost_empty=0. After 2 reads -> level 1, almost_empty=1 while empty=0. After the third read -> empty=1, almost_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and default geometry.
// Conversions work on a wide zero-extended vector so any pointer width up to PTR_MAX_W can use them.
package fifo_pkg;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int PTR_MAX_W       = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros of a narrower pointer stay zero through the prefix XOR.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ff_n.sv
// N-bit, STAGES-deep flop synchronizer with synchronous active-high reset to zero.
// Pure flop chain; nothing may be placed between stages.
module sync_ff_n #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stage_d [STAGES];
  logic [N-1:0] stage_q [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer/empty controller for the dual-clock FIFO.
// Optional almost-empty level compare is built only when FIFO_RD_ALMOST_EMPTY_EN is defined.
module fifo_rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AE_THRESH   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_fire,
  output logic              empty,
  output logic              underflow,
  output logic              almost_empty
);

  localparam int PTR_W = ADDR_W + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("fifo_rd_ptr_ctrl: SYNC_STAGES must be within 2..4");
  end
  if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_W)) begin : g_bad_ae_thresh
    $error("fifo_rd_ptr_ctrl: AE_THRESH must be within 0..2**ADDR_W");
  end

  logic [PTR_W-1:0] wq_sync;
  logic [PTR_W-1:0] rd_bin_d, rd_bin_q;
  logic [PTR_W-1:0] rd_gray_d, rd_gray_q;
  logic             empty_d, empty_q;
  logic             underflow_d, underflow_q;

  sync_ff_n #(
    .N      (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wq_sync (
    .clk (clk),
    .rst (rst),
    .d   (wr_ptr_gray),
    .q   (wq_sync)
  );

  // Empty compares the next read pointer against the current synced write
  // pointer, so draining the last entry raises empty on the same edge.
  always_comb begin
    rd_fire     = rd_en & ~empty_q;
    rd_bin_d    = rd_bin_q + PTR_W'(rd_fire);
    rd_gray_d   = PTR_W'(bin2gray(ptr_max_t'(rd_bin_d)));
    empty_d     = (rd_gray_d == wq_sync);
    underflow_d = rd_en & empty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wq_bin;
  logic [PTR_W-1:0] level;
  logic             almost_empty_d, almost_empty_q;

  // Level wraps modulo the full pointer width; the lap bit keeps it unambiguous.
  always_comb begin
    wq_bin         = PTR_W'(gray2bin(ptr_max_t'(wq_sync)));
    level          = wq_bin - rd_bin_d;
    almost_empty_d = (level <= AE_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_empty = almost_empty_q;
`else
  assign almost_empty = empty_q;
`endif

  assign rd_ptr_gray = rd_gray_q;
  assign rd_addr     = rd_bin_q[ADDR_W-1:0];
  assign empty       = empty_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Scoreboard bench for fifo_rd_ptr_ctrl with ADDR_W=2, SYNC_STAGES=2, AE_THRESH=1.
// Almost-empty level checks are active when FIFO_RD_ALMOST_EMPTY_EN is defined.
module tb_fifo_rd_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic [2:0] wr_ptr_gray = 3'b000;
  logic [2:0] rd_ptr_gray;
  logic [1:0] rd_addr;
  logic       rd_fire;
  logic       empty;
  logic       underflow;
  logic       almost_empty;

  fifo_rd_ptr_ctrl #(
    .ADDR_W      (2),
    .SYNC_STAGES (2),
    .AE_THRESH   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_ptr_gray  (rd_ptr_gray),
    .rd_addr      (rd_addr),
    .rd_fire      (rd_fire),
    .empty        (empty),
    .underflow    (underflow),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] gray;
    logic [1:0] addr;
    logic       empty;
    logic       uf;
    logic       ae;
  } exp_t;

  localparam logic [2:0] GRAY_TBL [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                          3'b110, 3'b111, 3'b101, 3'b100};

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       exp_q[$];
  logic [1:0] addr_log[$];

  int         m_bin   = 0;
  logic       m_empty = 1'b1;
  logic       m_known = 1'b0;
  logic [2:0] m_s0    = 3'b000;
  logic [2:0] m_s1    = 3'b000;

  function automatic logic [2:0] g_of(input int b);
    return GRAY_TBL[b % 8];
  endfunction

  function automatic int b_of(input logic [2:0] g);
    for (int i = 0; i < 8; i++) begin
      if (GRAY_TBL[i] == g) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive, predict, push; after the edge pop and compare.
  task automatic step(input logic r, input logic [2:0] w, input logic rs);
    exp_t e;
    int   fire;
    int   nb;
    @(negedge clk);
    rd_en       = r;
    wr_ptr_gray = w;
    rst         = rs;
    #1;
    if (m_known) chk("rd_fire", 32'(rd_fire), 32'(r & ~m_empty));
    if (rd_fire === 1'b1) addr_log.push_back(rd_addr);
    if (rs) begin
      m_bin   = 0;
      e.empty = 1'b1;
      e.uf    = 1'b0;
      e.ae    = 1'b1;
      m_s0    = 3'b000;
      m_s1    = 3'b000;
    end else begin
      fire    = (r && !m_empty) ? 1 : 0;
      e.uf    = r & m_empty;
      nb      = (m_bin + fire) % 8;
      e.empty = (g_of(nb) == m_s1);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      e.ae    = (((b_of(m_s1) - nb + 8) % 8) <= 1);
`else
      e.ae    = e.empty;
`endif
      m_bin   = nb;
      m_s1    = m_s0;
      m_s0    = w;
    end
    e.gray  = g_of(m_bin);
    e.addr  = 2'(m_bin % 4);
    m_empty = e.empty;
    m_known = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(e.gray));
    chk("rd_addr", 32'(rd_addr), 32'(e.addr));
    chk("empty", 32'(empty), 32'(e.empty));
    chk("underflow", 32'(underflow), 32'(e.uf));
    chk("almost_empty", 32'(almost_empty), 32'(e.ae));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with rd_en high
    step(1'b1, 3'b000, 1'b1);
    step(1'b1, 3'b000, 1'b1);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_gray", 32'(rd_ptr_gray), 32'd0);
    chk("t1_fire", 32'(rd_fire), 32'd0);

    // Write pointer 000->001: empty drops after the third edge, then one read
    step(1'b0, 3'b001, 1'b0);
    step(1'b0, 3'b001, 1'b0);
    chk("t2_empty_e2", 32'(empty), 32'd1);
    step(1'b0, 3'b001, 1'b0);
    chk("t2_empty_e3", 32'(empty), 32'd0);
    step(1'b1, 3'b001, 1'b0);
    chk("t2_gray", 32'(rd_ptr_gray), 32'(3'b001));
    chk("t2_addr", 32'(rd_addr), 32'd1);
    chk("t2_empty", 32'(empty), 32'd1);

    // Underflow pulse
    step(1'b1, 3'b001, 1'b0);
    chk("t3_uf", 32'(underflow), 32'd1);
    chk("t3_gray", 32'(rd_ptr_gray), 32'(3'b001));
    step(1'b0, 3'b001, 1'b0);
    chk("t3_uf_clr", 32'(underflow), 32'd0);

    // Wrap-around with continuous reads
    step(1'b0, 3'b000, 1'b1);
    addr_log.delete();
    for (int j = 1; j <= 8; j++) begin
      for (int k = 0; k < 4; k++) step(1'b1, g_of(j), 1'b0);
    end
    chk("t4_nreads", 32'(addr_log.size()), 32'd8);
    for (int i = 0; i < addr_log.size(); i++) begin
      chk("t4_addr_seq", 32'(addr_log[i]), 32'(i % 4));
    end
    chk("t4_gray", 32'(rd_ptr_gray), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);

    // Reset mid-operation at rd bin 5
    step(1'b0, 3'b000, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, g_of(3), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, g_of(5), 1'b0);
    chk("t5_pre_gray", 32'(rd_ptr_gray), 32'(3'b111));
    step(1'b1, g_of(5), 1'b1);
    chk("t5_gray", 32'(rd_ptr_gray), 32'd0);
    chk("t5_addr", 32'(rd_addr), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_uf", 32'(underflow), 32'd0);
    step(1'b0, g_of(5), 1'b0);

    // Almost-empty level walk: wr bin 3, three reads
    step(1'b0, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 3'b010, 1'b0);
    chk("t6_empty_lvl3", 32'(empty), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("t6_ae_lvl3", 32'(almost_empty), 32'd0);
`endif
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    chk("t6_empty_lvl1", 32'(empty), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("t6_ae_lvl1", 32'(almost_empty), 32'd1);
`endif
    step(1'b1, 3'b010, 1'b0);
    chk("t6_empty_lvl0", 32'(empty), 32'd1);
    chk("t6_ae_lvl0", 32'(almost_empty), 32'd1);
    step(1'b0, 3'b010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
